// File: rtl/serdes_pkg.sv
// Shared types and helpers for the SERDES phase-training controller.
package serdes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_NEXT,
        ST_SELECT,
        ST_LOCKED,
        ST_FAIL
    } trainer_state_e;

    localparam logic [31:0] DEFAULT_TRAIN_WORD = 32'hA5C3_5A3C;

    // Phase index width; never narrower than one bit.
    function automatic int PHASE_W(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serdes_phase_trainer_if.sv
// Control and receive-stream bundle between the phase trainer and its SERDES/host.
interface serdes_phase_trainer_if #(
    parameter int NUM_PHASES = 5
);
    import serdes_pkg::*;

    localparam int PW = PHASE_W(NUM_PHASES);

    logic                  start;
    logic [31:0]           rx_tdata;
    logic                  rx_tvalid;
    logic [PW-1:0]         phase_sel;
    logic                  tx_train_en;
    logic                  busy;
    logic                  link_up;
    logic                  train_fail;
    logic [NUM_PHASES-1:0] pass_map;

    modport master (
        input  start, rx_tdata, rx_tvalid,
        output phase_sel, tx_train_en, busy, link_up, train_fail, pass_map
    );

    modport slave (
        output start, rx_tdata, rx_tvalid,
        input  phase_sel, tx_train_en, busy, link_up, train_fail, pass_map
    );

endinterface

// File: rtl/serdes_phase_picker.sv
// Sequential scanner over two laps of the pass map; finds the centre of the
// widest circular run of passing phases, first-found run winning ties.
module serdes_phase_picker
    import serdes_pkg::*;
#(
    parameter int NUM_PHASES = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_scan,
    input  logic [NUM_PHASES-1:0]             pass_map,
    output logic                              done,
    output logic                              any_pass,
    output logic [PHASE_W(NUM_PHASES)-1:0]    best_phase
);

    localparam int PW = PHASE_W(NUM_PHASES);
    localparam int KW = $clog2(2 * NUM_PHASES);
    localparam int LW = $clog2(NUM_PHASES + 1);

    logic                  active_q, active_d;
    logic [NUM_PHASES-1:0] map_q, map_d;
    logic [KW-1:0]         k_q, k_d;
    logic [PW-1:0]         idx_q, idx_d;
    logic [PW-1:0]         run_start_q, run_start_d;
    logic [PW-1:0]         best_start_q, best_start_d;
    logic [LW-1:0]         run_len_q, run_len_d;
    logic [LW-1:0]         best_len_q, best_len_d;
    logic [LW-1:0]         half_len;
    logic [PW:0]           centre;

    always_comb begin
        active_d     = active_q;
        map_d        = map_q;
        k_d          = k_q;
        idx_d        = idx_q;
        run_start_d  = run_start_q;
        best_start_d = best_start_q;
        run_len_d    = run_len_q;
        best_len_d   = best_len_q;
        done         = 1'b0;
        if (start_scan) begin
            active_d     = 1'b1;
            map_d        = pass_map;
            k_d          = '0;
            idx_d        = '0;
            run_start_d  = '0;
            best_start_d = '0;
            run_len_d    = '0;
            best_len_d   = '0;
        end else if (active_q) begin
            if (map_q[idx_q]) begin
                if (run_len_q == '0) run_start_d = idx_q;
                // A full circle of passes must not count itself twice.
                if (run_len_q != LW'(NUM_PHASES)) run_len_d = run_len_q + 1'b1;
                if (run_len_d > best_len_q) begin
                    best_len_d   = run_len_d;
                    best_start_d = run_start_d;
                end
            end else begin
                run_len_d = '0;
            end
            idx_d = (idx_q == PW'(NUM_PHASES - 1)) ? '0 : idx_q + 1'b1;
            k_d   = k_q + 1'b1;
            if (k_q == KW'(2 * NUM_PHASES - 1)) begin
                active_d = 1'b0;
                done     = 1'b1;
            end
        end
    end

    // Centre is taken from the post-update values so the last scan step counts.
    always_comb begin
        half_len = (best_len_d - 1'b1) >> 1;
        centre   = {1'b0, best_start_d} + (PW+1)'(half_len);
        if (centre >= (PW+1)'(NUM_PHASES)) centre = centre - (PW+1)'(NUM_PHASES);
        best_phase = centre[PW-1:0];
        any_pass   = |map_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= 1'b0;
            map_q        <= '0;
            k_q          <= '0;
            idx_q        <= '0;
            run_start_q  <= '0;
            best_start_q <= '0;
            run_len_q    <= '0;
            best_len_q   <= '0;
        end else begin
            active_q     <= active_d;
            map_q        <= map_d;
            k_q          <= k_d;
            idx_q        <= idx_d;
            run_start_q  <= run_start_d;
            best_start_q <= best_start_d;
            run_len_q    <= run_len_d;
            best_len_q   <= best_len_d;
        end
    end

endmodule

// File: rtl/serdes_phase_trainer.sv
// Link-training controller: sweeps every receive phase against the training
// word, then locks onto the centre of the widest passing window.
module serdes_phase_trainer
    import serdes_pkg::*;
#(
    parameter int          NUM_PHASES    = 5,
    parameter logic [31:0] TRAIN_WORD    = DEFAULT_TRAIN_WORD,
    parameter int          SETTLE_CYCLES = 8,
    parameter int          DWELL_WORDS   = 16,
    parameter int          DWELL_TIMEOUT = 256
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_reset_n,
    serdes_phase_trainer_if.master bus
);

    localparam int PW = PHASE_W(NUM_PHASES);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(DWELL_WORDS + 1);
    localparam int TW = $clog2(DWELL_TIMEOUT + 1);

    trainer_state_e        state_q, state_d;
    logic [PW-1:0]         phase_sel_q, phase_sel_d;
    logic [NUM_PHASES-1:0] pass_map_q, pass_map_d;
    logic                  tx_train_en_q, tx_train_en_d;
    logic                  busy_q, busy_d;
    logic                  link_up_q, link_up_d;
    logic                  train_fail_q, train_fail_d;
    logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
    logic [MW-1:0]         match_cnt_q, match_cnt_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;

    logic                  scan_start;
    logic                  pick_done;
    logic                  pick_any;
    logic [PW-1:0]         pick_best;
    logic                  word_ok;

    serdes_phase_picker #(.NUM_PHASES(NUM_PHASES)) u_picker (
        .clk        (s_axis_aclk),
        .rst_n      (s_axis_reset_n),
        .start_scan (scan_start),
        .pass_map   (pass_map_q),
        .done       (pick_done),
        .any_pass   (pick_any),
        .best_phase (pick_best)
    );

    assign word_ok = (bus.rx_tdata == TRAIN_WORD);

    always_comb begin
        state_d       = state_q;
        phase_sel_d   = phase_sel_q;
        pass_map_d    = pass_map_q;
        tx_train_en_d = tx_train_en_q;
        busy_d        = busy_q;
        link_up_d     = link_up_q;
        train_fail_d  = train_fail_q;
        settle_cnt_d  = settle_cnt_q;
        match_cnt_d   = match_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        scan_start    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
                if (bus.start) begin
                    phase_sel_d   = '0;
                    pass_map_d    = '0;
                    link_up_d     = 1'b0;
                    train_fail_d  = 1'b0;
                    busy_d        = 1'b1;
                    tx_train_en_d = 1'b1;
                    settle_cnt_d  = '0;
                    state_d       = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_cnt_d = '0;
                    match_cnt_d  = '0;
                    tmo_cnt_d    = '0;
                    state_d      = ST_DWELL;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_DWELL: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // A pass on the timeout cycle still counts as a pass.
                if (bus.rx_tvalid && word_ok) begin
                    match_cnt_d = match_cnt_q + 1'b1;
                    if (match_cnt_q == MW'(DWELL_WORDS - 1)) begin
                        pass_map_d[phase_sel_q] = 1'b1;
                        state_d = ST_NEXT;
                    end else if (tmo_cnt_q == TW'(DWELL_TIMEOUT - 1)) begin
                        state_d = ST_NEXT;
                    end
                end else if (bus.rx_tvalid || (tmo_cnt_q == TW'(DWELL_TIMEOUT - 1))) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (phase_sel_q == PW'(NUM_PHASES - 1)) begin
                    scan_start = 1'b1;
                    state_d    = ST_SELECT;
                end else begin
                    phase_sel_d  = phase_sel_q + 1'b1;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SELECT: begin
                if (pick_done) begin
                    tx_train_en_d = 1'b0;
                    busy_d        = 1'b0;
                    if (pick_any) begin
                        phase_sel_d = pick_best;
                        link_up_d   = 1'b1;
                        state_d     = ST_LOCKED;
                    end else begin
                        phase_sel_d  = '0;
                        train_fail_d = 1'b1;
                        state_d      = ST_FAIL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
        if (!s_axis_reset_n) begin
            state_q       <= ST_IDLE;
            phase_sel_q   <= '0;
            pass_map_q    <= '0;
            tx_train_en_q <= 1'b0;
            busy_q        <= 1'b0;
            link_up_q     <= 1'b0;
            train_fail_q  <= 1'b0;
            settle_cnt_q  <= '0;
            match_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            phase_sel_q   <= phase_sel_d;
            pass_map_q    <= pass_map_d;
            tx_train_en_q <= tx_train_en_d;
            busy_q        <= busy_d;
            link_up_q     <= link_up_d;
            train_fail_q  <= train_fail_d;
            settle_cnt_q  <= settle_cnt_d;
            match_cnt_q   <= match_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign bus.phase_sel   = phase_sel_q;
    assign bus.pass_map    = pass_map_q;
    assign bus.tx_train_en = tx_train_en_q;
    assign bus.busy        = busy_q;
    assign bus.link_up     = link_up_q;
    assign bus.train_fail  = train_fail_q;

endmodule

// File: tb/tb_serdes_phase_trainer.sv
// Scoreboard bench: a loopback emulator plays a per-phase receive behaviour,
// a reference model predicts each training outcome, a monitor checks it.
module tb_serdes_phase_trainer;

    localparam int          N     = 5;
    localparam logic [31:0] TW    = 32'hA5C3_5A3C;
    localparam logic [31:0] BADW  = 32'hDEAD_BEEF;

    localparam int M_GOOD   = 0;
    localparam int M_GAPPY  = 1;
    localparam int M_BAD    = 2;
    localparam int M_SILENT = 3;

    typedef struct {
        logic [31:0] pass_map;
        logic [31:0] phase_sel;
        logic [31:0] link_up;
        logic [31:0] train_fail;
        int          busy_len;
        bit          chk_len;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serdes_phase_trainer_if #(.NUM_PHASES(N)) bus ();

    serdes_phase_trainer #(.NUM_PHASES(N)) dut (
        .s_axis_aclk    (clk),
        .s_axis_reset_n (rst_n),
        .bus            (bus)
    );

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   mode [N];
    exp_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: longest maximal circular run of passes, lowest start index on ties.
    function automatic exp_t predict();
        exp_t        e;
        logic [N-1:0] pm;
        int          best_s, best_l, len, cycles;
        bit          gappy;
        pm = '0; cycles = 2 * N; gappy = 0;
        for (int p = 0; p < N; p++) begin
            pm[p] = (mode[p] == M_GOOD) || (mode[p] == M_GAPPY);
            case (mode[p])
                M_GOOD:   cycles += 8 + 16 + 1;
                M_BAD:    cycles += 8 + 1 + 1;
                M_SILENT: cycles += 8 + 256 + 1;
                default:  gappy = 1;
            endcase
        end
        best_s = 0; best_l = 0;
        if (pm == '0) begin
            best_s = 0;
        end else if (pm == '1) begin
            best_s = (N - 1) / 2; best_l = N;
        end else begin
            for (int s = 0; s < N; s++) begin
                if (pm[s] && !pm[(s + N - 1) % N]) begin
                    len = 0;
                    while (pm[(s + len) % N]) len++;
                    if (len > best_l) begin best_l = len; best_s = s; end
                end
            end
            best_s = (best_s + (best_l - 1) / 2) % N;
        end
        e.pass_map   = 32'(pm);
        e.phase_sel  = 32'(best_s);
        e.link_up    = (pm != '0) ? 32'd1 : 32'd0;
        e.train_fail = (pm == '0) ? 32'd1 : 32'd0;
        e.busy_len   = cycles;
        e.chk_len    = !gappy;
        return e;
    endfunction

    // Loopback emulator: the receive stream depends on the phase being sampled.
    always @(negedge clk) begin
        case (mode[bus.phase_sel])
            M_GOOD:   begin bus.rx_tvalid = 1'b1; bus.rx_tdata = TW; end
            M_GAPPY:  begin bus.rx_tvalid = ($urandom_range(0, 3) != 0); bus.rx_tdata = TW; end
            M_BAD:    begin bus.rx_tvalid = 1'b1; bus.rx_tdata = BADW; end
            default:  begin bus.rx_tvalid = 1'b0; bus.rx_tdata = $urandom; end
        endcase
    end

    // Monitor: every busy fall is one completed training.
    int   busy_cnt  = 0;
    bit   busy_prev = 0;
    exp_t m_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 0;
            busy_cnt  = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (busy_prev && !bus.busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    $display("[TB] train %0d: pass_map=%b phase_sel=%0d link_up=%0d fail=%0d busy=%0d",
                             done_cnt, bus.pass_map, bus.phase_sel, bus.link_up, bus.train_fail, busy_cnt);
                    check("pass_map",    32'(bus.pass_map),   m_e.pass_map);
                    check("phase_sel",   32'(bus.phase_sel),  m_e.phase_sel);
                    check("link_up",     32'(bus.link_up),    m_e.link_up);
                    check("train_fail",  32'(bus.train_fail), m_e.train_fail);
                    check("tx_train_en", 32'(bus.tx_train_en), 32'd0);
                    if (m_e.chk_len) check("busy_len", 32'(busy_cnt), 32'(m_e.busy_len));
                end
                done_cnt++;
                busy_cnt = 0;
            end
            busy_prev = bus.busy;
        end
    end

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic train(input bit restart_mid, input bit chk_launch);
        int target;
        target = done_cnt + 1;
        exp_q.push_back(predict());
        pulse_start();
        if (chk_launch) begin
            check("launch_link_up",  32'(bus.link_up),     32'd0);
            check("launch_tx_train", 32'(bus.tx_train_en), 32'd1);
            check("launch_busy",     32'(bus.busy),        32'd1);
            check("launch_pass_map", 32'(bus.pass_map),    32'd0);
        end
        if (restart_mid) begin
            repeat (12) @(negedge clk);
            pulse_start();
        end
        for (int i = 0; i < 4000 && done_cnt < target; i++) @(negedge clk);
        if (done_cnt < target) begin
            check("train_timeout", 32'(done_cnt), 32'(target));
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic set_modes(input int m0, input int m1, input int m2, input int m3, input int m4);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3; mode[4] = m4;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.rx_tvalid = 1'b0;
        bus.rx_tdata = '0;
        set_modes(M_GOOD, M_GOOD, M_GOOD, M_GOOD, M_GOOD);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_phase_sel",  32'(bus.phase_sel),   32'd0);
        check("rst_pass_map",   32'(bus.pass_map),    32'd0);
        check("rst_busy",       32'(bus.busy),        32'd0);
        check("rst_link_up",    32'(bus.link_up),     32'd0);
        check("rst_train_fail", 32'(bus.train_fail),  32'd0);
        check("rst_tx_train",   32'(bus.tx_train_en), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All phases good; a second start mid-DWELL must not restart the sweep.
        train(1'b1, 1'b1);
        // Retrain from LOCKED with phases 1 and 2 corrupted.
        set_modes(M_GOOD, M_BAD, M_BAD, M_GOOD, M_GOOD);
        train(1'b0, 1'b1);
        set_modes(M_GOOD, M_BAD, M_GOOD, M_BAD, M_BAD);
        train(1'b0, 1'b0);
        set_modes(M_GOOD, M_BAD, M_BAD, M_BAD, M_GOOD);
        train(1'b0, 1'b0);
        set_modes(M_SILENT, M_SILENT, M_SILENT, M_SILENT, M_SILENT);
        train(1'b0, 1'b0);
        set_modes(M_GOOD, M_GOOD, M_GOOD, M_BAD, M_GOOD);
        train(1'b0, 1'b1);

        // Asynchronous reset in the middle of phase 2 dwell.
        set_modes(M_GOOD, M_GOOD, M_GOOD, M_GOOD, M_GOOD);
        pulse_start();
        repeat (61) @(negedge clk);
        check("pre_rst_phase_sel", 32'(bus.phase_sel), 32'd2);
        check("pre_rst_pass_map",  32'(bus.pass_map),  32'd3);
        check("pre_rst_busy",      32'(bus.busy),      32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_phase_sel", 32'(bus.phase_sel),   32'd0);
        check("async_pass_map",  32'(bus.pass_map),    32'd0);
        check("async_busy",      32'(bus.busy),        32'd0);
        check("async_tx_train",  32'(bus.tx_train_en), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        train(1'b0, 1'b1);

        for (int t = 0; t < 10; t++) begin
            for (int p = 0; p < N; p++) begin
                int r;
                r = $urandom_range(0, 9);
                mode[p] = (r < 5) ? M_GOOD : (r < 7) ? M_GAPPY : (r < 9) ? M_BAD : M_SILENT;
            end
            train(1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_phase_trainer.md
Name: serdes_phase_trainer

Overview:
- Link-training controller for the multi-phase AXI-stream SERDES.
- Sweeps the receive sampling phase across all NUM_PHASES clock phases while the transmitter sends a fixed training word, and scores each phase against that word.
- Selects the centre of the widest circular window of passing phases, then drives the phase select and releases the link for data.
- Sits beside top_axi_serdes on the stream clock and owns its phase mux and training-mode enable.

Parameters:
- NUM_PHASES, 5, number of sampling clock phases (at least 2).
- TRAIN_WORD, 32'hA5C3_5A3C, word the TX sends while tx_train_en=1.
- SETTLE_CYCLES, 8, clocks discarded after each phase change.
- DWELL_WORDS, 16, consecutive matching valid words required for a phase to pass.
- DWELL_TIMEOUT, 256, clocks allowed in DWELL before the phase is failed.

Ports:
- s_axis_aclk  in  1  stream clock; the only clock.
- s_axis_reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to (re)train.
- rx_tdata  in  32  deserialized word.
- rx_tvalid  in  1  rx_tdata qualifier.
- phase_sel  out  $clog2(NUM_PHASES)  sampling phase index to the SERDES.
- tx_train_en  out  1  TX sends TRAIN_WORD while high.
- busy  out  1  training in progress.
- link_up  out  1  locked on best phase.
- train_fail  out  1  last training found no passing phase.
- pass_map  out  NUM_PHASES  per-phase pass bits from the last sweep.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. Reset asserted mid-operation aborts immediately, with no completion of the sweep.
- States: IDLE, SETTLE, DWELL, NEXT, SELECT, LOCKED, FAIL.
- IDLE/LOCKED/FAIL, start=1: phase_sel<=0, pass_map<=0, link_up<=0, train_fail<=0, busy<=1, tx_train_en<=1, go to SETTLE.
- start is ignored in every other state.
- SETTLE: count SETTLE_CYCLES clocks; rx input ignored; then DWELL with match and timeout counters cleared.
- DWELL: each cycle with rx_tvalid=1 compares rx_tdata to TRAIN_WORD.
  - Match: match count +1. Reaching DWELL_WORDS sets pass_map[phase_sel]=1 and goes to NEXT.
  - Mismatch: immediate early-out to NEXT with the pass bit left at 0.
  - rx_tvalid=0: match counter holds; the timeout counter runs every DWELL cycle.
  - Timeout reaching DWELL_TIMEOUT: go to NEXT with the phase failed.
  - A match and the timeout in the same cycle: the match/pass decision wins.
- NEXT: if phase_sel==NUM_PHASES-1, go to SELECT; else phase_sel+1 and go to SETTLE. No wrap past NUM_PHASES-1.
- SELECT: takes exactly 2*NUM_PHASES clocks.
  - Scans k=0..2N-1 over pass_map[k mod N], tracking the current run start and run length (length capped at N).
  - Best run is replaced only when the length is strictly greater, so the first-found run wins ties.
  - best = (start + (len-1)/2) mod N.
  - All pass: best=(N-1)/2.
- SELECT exit, some phase passed: phase_sel<=best, tx_train_en<=0, busy<=0, link_up<=1, go to LOCKED.
- SELECT exit, no phase passed: phase_sel<=0, tx_train_en<=0, busy<=0, train_fail<=1, go to FAIL.
- LOCKED/FAIL: outputs hold until start or reset.
- All outputs are registered. Width of phase_sel is max(1,$clog2(NUM_PHASES)).

Decomposition:
- Package serdes_pkg:
  - trainer state enum.
  - DEFAULT_TRAIN_WORD constant.
  - PHASE_W function max(1,$clog2(n)).
- Sub-module serdes_phase_picker:
  - Sequential circular-window scanner.
  - Inputs: start_scan, pass_map.
  - Outputs: done, any_pass, best_phase.
  - Instanced by the SELECT state.

Test Plan:
- Defaults; TX loopback always emits TRAIN_WORD with rx_tvalid=1; pulse start -> pass_map=5'b11111, phase_sel=2, link_up=1, busy=0, tx_train_en=0. busy length = 5*(8+16+1)+10 clocks, ±2 for state-entry cycles.
- Corrupt rx_tdata (0xDEADBEEF) while phase_sel is 1 or 2 -> pass_map=5'b11001, wrap run {3,4,0} gives phase_sel=4, link_up=1.
- Pass only phases 0 and 2 -> equal runs, first found wins -> phase_sel=0. Separately, pass {0,4} -> phase_sel=4.
- Hold rx_tvalid=0 throughout -> each phase times out after 256 clocks -> pass_map=0, train_fail=1, link_up=0, phase_sel=0.
- Pulse start again during DWELL -> ignored. Then assert reset mid-DWELL -> all outputs 0 in the same cycle (asynchronous). After release a new start trains normally.
- From LOCKED, pulse start -> link_up falls the next clock and tx_train_en rises. A single mismatch at phase 3 gives an early-out: NEXT is entered on the mismatch cycle +1.
